imm_gen_stage: RTL and testbench
================================

Name: imm_gen_stage

Overview:
- Registered, handshaked immediate-generation stage between fetch and execute.
- Decodes the immediate for every RV32I format (I, S, B, J, U, shift-amount, CSR zimm), sign- or zero-extended to XLEN.
- Computes the PC-relative target Pc + Immediate.
- Valid/ready on both sides, optional 2-entry skid buffer, synchronous flush for branch redirect.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  Instruction/Pc/ImmSel valid.
- in_ready  output  1  stage can accept this cycle.
- Instruction  input  32  raw instruction word.
- Pc  input  XLEN  address of Instruction.
- ImmSel  input  3  format select: 000 I, 001 S, 010 B, 011 J, 100 U, 101 shamt, 110 CSR zimm, 111 zero.
- flush  input  1  synchronous kill of all held entries.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts.
- Immediate  output  XLEN  extended immediate.
- Target  output  XLEN  Pc + Immediate, modulo 2^XLEN.
- out_pc  output  XLEN  Pc carried with the result.

Behaviour:
- **Format decode** (combinational, from Instruction):
  - I: sign-extend [31:20].
  - S: sign-extend {[31:25],[11:7]}.
  - B: sign-extend {[31],[7],[30:25],[11:8],1'b0}; LSB always 0.
  - J: sign-extend {[31],[19:12],[20],[30:21],1'b0}; LSB always 0.
  - U: {[31:12],12'b0}, sign-extended to XLEN when XLEN=64.
  - shamt: zero-extend [24:20] (XLEN=32) or [25:20] (XLEN=64).
  - zimm: zero-extend [19:15].
  - 111: all zero.
- **Target:** Pc + decoded Immediate, XLEN-bit add, carry discarded. Computed before the register, so both are registered together.
- **Latency:** exactly 1 cycle from accept (in_valid & in_ready) to out_valid when the stage is empty.
- **Entries:** out register (drives outputs) and, when SKID=1, a skid register.
- **SKID=1 rules:**
  - in_ready = ~skid_valid, registered.
  - On accept: if ~out_valid or out_ready, load the out register; otherwise load the skid.
  - On output fire (out_valid & out_ready) with skid_valid: skid moves to out and skid empties in the same edge.
  - Simultaneous fire + accept with skid empty: the new entry loads out directly.
  - Order is strictly FIFO.
- **SKID=0 rules:**
  - in_ready = ~out_valid | out_ready, combinational.
  - Accept loads out.
  - Fire without accept clears out_valid.
- **Stability:** while out_valid & ~out_ready, Immediate, Target and out_pc hold stable. Data registers load only on a write (no needless toggling).
- **Flush:**
  - Next edge clears out_valid and skid_valid.
  - Any accept in the same cycle is dropped.
  - Flush has priority over accept and fire.
  - Data registers are not required to clear.
- **Reset (async assert, sync-release-safe):**
  - out_valid=0, skid_valid=0.
  - Immediate=0, Target=0, out_pc=0.
  - in_ready=1 during and after reset.
- **Reset mid-operation:** all entries are discarded immediately with no partial output.
- **ImmSel 111 or unused encodings:** Immediate=0, Target=Pc.
- **Protocol:** in_valid may drop without acceptance (no input hold requirement). out_valid, once asserted, stays high with stable data until fired or flushed.

Test Plan:
- **Format sweep:** single accepts at Pc=0x100, out_ready=1; each result appears 1 cycle later.
  - I: 0xFFF00093 -> Immediate 0xFFFFFFFF, Target 0x000000FF.
  - S: 0xFE20AE23 -> 0xFFFFFFFC.
  - B: 0xFE000CE3 -> Immediate 0xFFFFFFF8, Target 0x000000F8.
  - J: 0x0010006F -> Immediate 0x00000800, Target 0x00000900.
  - U: 0x123450B7 -> 0x12345000.
  - shamt: 0x01F0D093 -> 0x0000001F.
- **Target wrap:** Pc=0xFFFFFFFC, J 0x0080006F (+8) -> Target 0x00000004.
- **Backpressure (SKID=1):** out_ready=0; offer A, B, C back-to-back.
  - A held in out, B in skid, in_ready=0 from cycle 2, C not accepted.
  - Raise out_ready: A, B, C emerge in order on consecutive cycles.
- **Flush:** with out and skid full, assert flush alongside in_valid (D).
  - Next cycle: out_valid=0, in_ready=1, D never emerges.
- **Async reset:** drop rst_n mid-stream between edges.
  - out_valid=0 and Immediate=0 immediately, without waiting for clk.
  - After release, a new accept produces a result 1 cycle later.
- **SKID=0, XLEN=64 build:** alternate out_ready 1/0 with continuous in_valid.
  - in_ready tracks ~out_valid|out_ready combinationally.
  - I 0xFFF00093 -> 0xFFFFFFFFFFFFFFFF.
  - shamt 0x03F0D093 -> 0x3F.

Source files
------------

// File: rtl/imm_gen_stage.sv
// Immediate-generation pipeline stage: decodes the RV32I immediate, computes Pc + Immediate,
// and registers the result behind a valid/ready handshake with an optional two-entry skid buffer.
module imm_gen_stage #(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     Instruction,
  input  logic [XLEN-1:0] Pc,
  input  logic [2:0]      ImmSel,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Immediate,
  output logic [XLEN-1:0] Target,
  output logic [XLEN-1:0] out_pc
);

  logic [31:0]     imm32;
  logic            sext;
  logic [XLEN-1:0] imm_dec;
  logic [XLEN-1:0] tgt_dec;

  logic            skid_valid;
  logic [XLEN-1:0] skid_imm;
  logic [XLEN-1:0] skid_tgt;
  logic [XLEN-1:0] skid_pc;

  logic            out_free;
  logic            accept;
  logic            load_out;
  logic            load_skid;

  // Opcode bits play no part in immediate extraction.
  wire unused_bits = &{1'b0, Instruction[6:0]};

  // imm32 is already sign-extended to 32 bits; sext widens it further when XLEN=64.
  always_comb begin
    imm32 = '0;
    sext  = 1'b0;
    case (ImmSel)
      3'b000: begin
        imm32 = {{20{Instruction[31]}}, Instruction[31:20]};
        sext  = 1'b1;
      end
      3'b001: begin
        imm32 = {{20{Instruction[31]}}, Instruction[31:25], Instruction[11:7]};
        sext  = 1'b1;
      end
      3'b010: begin
        imm32 = {{19{Instruction[31]}}, Instruction[31], Instruction[7],
                 Instruction[30:25], Instruction[11:8], 1'b0};
        sext  = 1'b1;
      end
      3'b011: begin
        imm32 = {{11{Instruction[31]}}, Instruction[31], Instruction[19:12],
                 Instruction[20], Instruction[30:21], 1'b0};
        sext  = 1'b1;
      end
      3'b100: begin
        imm32 = {Instruction[31:12], 12'b0};
        sext  = 1'b1;
      end
      3'b101: imm32 = (XLEN == 64) ? {26'b0, Instruction[25:20]} : {27'b0, Instruction[24:20]};
      3'b110: imm32 = {27'b0, Instruction[19:15]};
      default: imm32 = '0;
    endcase

    imm_dec = XLEN'(imm32);
    if (sext && imm32[31]) imm_dec = imm_dec | ~XLEN'(32'hFFFF_FFFF);
  end

  assign tgt_dec = Pc + imm_dec;

  assign out_free  = ~out_valid | out_ready;
  assign accept    = in_valid & in_ready & ~flush;
  assign load_out  = ~flush & out_free & (skid_valid | accept);
  assign load_skid = ~flush & ~out_free & accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (out_free) begin
      out_valid <= skid_valid | accept;
    end
  end

  // A parked skid entry always wins the out register so order stays FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Immediate <= '0;
      Target    <= '0;
      out_pc    <= '0;
    end else if (load_out) begin
      if (skid_valid) begin
        Immediate <= skid_imm;
        Target    <= skid_tgt;
        out_pc    <= skid_pc;
      end else begin
        Immediate <= imm_dec;
        Target    <= tgt_dec;
        out_pc    <= Pc;
      end
    end
  end

  if (SKID != 0) begin : g_skid
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        skid_valid <= 1'b0;
      end else if (flush || out_free) begin
        skid_valid <= 1'b0;
      end else if (accept) begin
        skid_valid <= 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        skid_imm <= '0;
        skid_tgt <= '0;
        skid_pc  <= '0;
      end else if (load_skid) begin
        skid_imm <= imm_dec;
        skid_tgt <= tgt_dec;
        skid_pc  <= Pc;
      end
    end

    assign in_ready = ~skid_valid;
  end else begin : g_noskid
    assign skid_valid = 1'b0;
    assign skid_imm   = '0;
    assign skid_tgt   = '0;
    assign skid_pc    = '0;
    assign in_ready   = out_free;
  end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench: format table on a 32-bit skid build, plus backpressure, flush, async reset
// and a 64-bit single-register build.
module tb_imm_gen_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 32-bit, SKID=1 instance
  logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
  logic [31:0] a_ins, a_pc, a_imm, a_tgt, a_opc;
  logic [2:0]  a_sel;

  // 64-bit, SKID=0 instance
  logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
  logic [31:0] b_ins;
  logic [63:0] b_pc, b_imm, b_tgt, b_opc;
  logic [2:0]  b_sel;

  imm_gen_stage #(.XLEN(32), .SKID(1)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .Instruction(a_ins), .Pc(a_pc), .ImmSel(a_sel), .flush(a_flush),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .Immediate(a_imm), .Target(a_tgt), .out_pc(a_opc)
  );

  imm_gen_stage #(.XLEN(64), .SKID(0)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .Instruction(b_ins), .Pc(b_pc), .ImmSel(b_sel), .flush(b_flush),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .Immediate(b_imm), .Target(b_tgt), .out_pc(b_opc)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic [2:0]  sel;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] tgt;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [31:0] ins, input logic [2:0] sel,
                         input logic [31:0] pc);
    a_in_valid = v;
    a_ins      = ins;
    a_sel      = sel;
    a_pc       = pc;
  endtask

  initial begin
    vecs[0] = '{"fmt_i",     32'hFFF00093, 3'b000, 32'h100,      32'hFFFFFFFF, 32'h000000FF};
    vecs[1] = '{"fmt_s",     32'hFE20AE23, 3'b001, 32'h100,      32'hFFFFFFFC, 32'h000000FC};
    vecs[2] = '{"fmt_b",     32'hFE000CE3, 3'b010, 32'h100,      32'hFFFFFFF8, 32'h000000F8};
    vecs[3] = '{"fmt_j",     32'h0010006F, 3'b011, 32'h100,      32'h00000800, 32'h00000900};
    vecs[4] = '{"fmt_u",     32'h123450B7, 3'b100, 32'h100,      32'h12345000, 32'h12345100};
    vecs[5] = '{"fmt_shamt", 32'h01F0D093, 3'b101, 32'h100,      32'h0000001F, 32'h0000011F};
    vecs[6] = '{"fmt_zimm",  32'h800FD073, 3'b110, 32'h100,      32'h0000001F, 32'h0000011F};
    vecs[7] = '{"fmt_zero",  32'hFFFFFFFF, 3'b111, 32'h100,      32'h00000000, 32'h00000100};
    vecs[8] = '{"tgt_wrap",  32'h0080006F, 3'b011, 32'hFFFFFFFC, 32'h00000008, 32'h00000004};
    vecs[9] = '{"fmt_i_pos", 32'h7FF00093, 3'b000, 32'h400,      32'h000007FF, 32'h00000BFF};

    drive_a(1'b0, 32'h0, 3'b000, 32'h0);
    a_flush = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_ins = 32'h0; b_sel = 3'b000; b_pc = 64'h0;
    b_flush = 1'b0; b_out_ready = 1'b1;

    #1;
    chk("rst_in_ready",  a_in_ready, 1);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_imm",       a_imm, 0);
    chk("rst_tgt",       a_tgt, 0);
    chk("rst_out_pc",    a_opc, 0);
    chk("rst_b_in_ready", b_in_ready, 1);
    #11 rst_n = 1'b1;
    chk("post_rst_in_ready", a_in_ready, 1);

    // Format sweep, one accept per cycle with the consumer always ready.
    for (int i = 0; i < 10; i++) begin
      drive_a(1'b1, vecs[i].ins, vecs[i].sel, vecs[i].pc);
      tick();
      chk({vecs[i].name, "_valid"}, a_out_valid, 1);
      chk({vecs[i].name, "_imm"},   a_imm, vecs[i].imm);
      chk({vecs[i].name, "_tgt"},   a_tgt, vecs[i].tgt);
      chk({vecs[i].name, "_pc"},    a_opc, vecs[i].pc);
    end
    drive_a(1'b0, 32'h0, 3'b000, 32'h0);
    tick();
    chk("drain_valid", a_out_valid, 0);

    // Backpressure: A in out, B in skid, C refused until the skid drains.
    a_out_ready = 1'b0;
    drive_a(1'b1, 32'h00100093, 3'b000, 32'h200);
    tick();
    chk("bp_a_valid", a_out_valid, 1);
    chk("bp_in_ready_1", a_in_ready, 1);
    drive_a(1'b1, 32'h00200093, 3'b000, 32'h204);
    tick();
    chk("bp_in_ready_2", a_in_ready, 0);
    chk("bp_hold_a", a_imm, 1);
    drive_a(1'b1, 32'h00300093, 3'b000, 32'h208);
    tick();
    chk("bp_c_refused", a_in_ready, 0);
    chk("bp_still_a", a_imm, 1);
    chk("bp_still_a_pc", a_opc, 32'h200);
    a_out_ready = 1'b1;
    tick();
    chk("bp_b_valid", a_out_valid, 1);
    chk("bp_b_imm", a_imm, 2);
    chk("bp_b_tgt", a_tgt, 32'h206);
    tick();
    drive_a(1'b0, 32'h0, 3'b000, 32'h0);
    chk("bp_c_valid", a_out_valid, 1);
    chk("bp_c_imm", a_imm, 3);
    chk("bp_c_pc", a_opc, 32'h208);
    tick();
    chk("bp_empty", a_out_valid, 0);

    // Flush with both entries full, then flush racing an accept into an empty stage.
    a_out_ready = 1'b0;
    drive_a(1'b1, 32'h00100093, 3'b000, 32'h300);
    tick();
    drive_a(1'b1, 32'h00200093, 3'b000, 32'h304);
    tick();
    chk("fl_full", a_in_ready, 0);
    drive_a(1'b1, 32'h00400093, 3'b000, 32'h308);
    a_flush = 1'b1;
    tick();
    chk("fl_out_valid", a_out_valid, 0);
    chk("fl_in_ready", a_in_ready, 1);
    tick();
    chk("fl_d_dropped", a_out_valid, 0);
    a_flush = 1'b0;
    drive_a(1'b0, 32'h0, 3'b000, 32'h0);
    a_out_ready = 1'b1;
    tick();
    chk("fl_d_never", a_out_valid, 0);

    // Asynchronous reset between edges.
    drive_a(1'b1, 32'h00500093, 3'b000, 32'h500);
    tick();
    chk("ar_loaded", a_out_valid, 1);
    drive_a(1'b0, 32'h0, 3'b000, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid_now", a_out_valid, 0);
    chk("ar_imm_now", a_imm, 0);
    chk("ar_in_ready", a_in_ready, 1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    drive_a(1'b1, 32'h00600093, 3'b000, 32'h600);
    tick();
    chk("ar_new_valid", a_out_valid, 1);
    chk("ar_new_imm", a_imm, 6);
    chk("ar_new_tgt", a_tgt, 32'h606);
    drive_a(1'b0, 32'h0, 3'b000, 32'h0);
    tick();

    // 64-bit, single register, combinational in_ready.
    b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_ins = 32'hFFF00093; b_sel = 3'b000; b_pc = 64'h1000;
    #1;
    chk("s0_rdy_empty", b_in_ready, 1);
    tick();
    chk("s0_i_valid", b_out_valid, 1);
    chk("s0_i_imm", b_imm, 64'hFFFFFFFFFFFFFFFF);
    chk("s0_i_tgt", b_tgt, 64'h0000000000000FFF);
    chk("s0_rdy_blocked", b_in_ready, 0);
    b_out_ready = 1'b1;
    b_ins = 32'h03F0D093; b_sel = 3'b101;
    #1;
    chk("s0_rdy_comb", b_in_ready, 1);
    tick();
    chk("s0_sh_imm", b_imm, 64'h3F);
    chk("s0_sh_tgt", b_tgt, 64'h103F);
    b_out_ready = 1'b0;
    b_ins = 32'h800000B7; b_sel = 3'b100;
    #1;
    chk("s0_rdy_low", b_in_ready, 0);
    tick();
    chk("s0_hold_imm", b_imm, 64'h3F);
    chk("s0_hold_valid", b_out_valid, 1);
    b_out_ready = 1'b1;
    tick();
    chk("s0_u_imm", b_imm, 64'hFFFFFFFF80000000);
    chk("s0_u_tgt", b_tgt, 64'hFFFFFFFF80001000);
    b_in_valid = 1'b0;
    tick();
    chk("s0_empty", b_out_valid, 0);
    b_out_ready = 1'b0;
    #1;
    chk("s0_rdy_idle", b_in_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
